// File: rtl/mem_responder.sv
// Memory-side responder for the datapath RAM port: edge-triggered read/write
// requests, programmable wait states, registered read data and a done pulse.
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // The wait counter is 4 bits wide, so larger settings saturate at 15.
    localparam int WS_EFF = (WAIT_STATES > 15) ? 15 : ((WAIT_STATES < 0) ? 0 : WAIT_STATES);
    localparam logic [3:0] CNT_INIT = (WS_EFF > 0) ? 4'(WS_EFF - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  req_prev_q;
    logic                  op_write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  err_q;

    logic req_d;
    logic new_req_d;
    logic commit_wr_d;

    assign req_d       = read | write;
    assign new_req_d   = req_d & ~req_prev_q;
    // A clear sampled on the ACCESS edge aborts the write as well.
    assign commit_wr_d = ~clear & (state_q == ST_ACCESS) & op_write_q;

    always_ff @(posedge clock) begin
        if (commit_wr_d) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            req_prev_q <= 1'b1;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            req_prev_q <= req_d;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // busy is still high during the done cycle; requests then are dropped.
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (new_req_d) begin
                        if (read & write) begin
                            err_q <= 1'b1;
                        end else begin
                            op_write_q <= write;
                            addr_q     <= address;
                            wdata_q    <= data_in;
                            busy_q     <= 1'b1;
                            cnt_q      <= CNT_INIT;
                            if (WS_EFF > 0) begin
                                state_q <= ST_WAIT;
                            end else begin
                                state_q <= ST_ACCESS;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (!op_write_q) begin
                        data_out_q <= mem_q[addr_q];
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_STATES 1, 0, 3) checked against
// a scoreboard of expected done cycles and data_out values.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rd = '0;
    logic [2:0]  wr = '0;
    logic [2:0]  clr = 3'b111;
    logic [2:0]  done_w;
    logic [2:0]  busy_w;
    logic [2:0]  err_w;
    logic [8:0]  addr_w [3];
    logic [31:0] din_w  [3];
    logic [31:0] dout_w [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          inst;
        logic [31:0] dout;
        int          due;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [int];
    logic [31:0] exp_dout [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            mem_responder #(
                .DATA_WIDTH (32),
                .ADDR_WIDTH (9),
                .WAIT_STATES((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
            ) u_dut (
                .clock   (clk),
                .clear   (clr[gi]),
                .read    (rd[gi]),
                .write   (wr[gi]),
                .address (addr_w[gi]),
                .data_in (din_w[gi]),
                .data_out(dout_w[gi]),
                .done    (done_w[gi]),
                .busy    (busy_w[gi]),
                .err     (err_w[gi])
            );
        end
    endgenerate

    function automatic int ws(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (done_w[i] === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done inst%0d cycle=%0d: got done=1, expected done=0", i, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.inst != i || e.due != cyc || dout_w[i] !== e.dout) begin
                        errors++;
                        $display("FAIL done_match: got inst=%0d cycle=%0d data_out=%h, expected inst=%0d cycle=%0d data_out=%h",
                                 i, cyc, dout_w[i], e.inst, e.due, e.dout);
                    end else begin
                        $display("done inst%0d cycle=%0d data_out=%h ok", i, cyc, dout_w[i]);
                    end
                end
            end
        end
    end

    task automatic wait_drain(input int i);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout inst%0d: got %0d pending, expected 0", i, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy_w[i] !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_done inst%0d: got %b, expected 0", i, busy_w[i]);
        end
    endtask

    task automatic do_req(input int i, input logic r, input logic w, input logic [8:0] a,
                          input logic [31:0] d, input int hold, input logic scramble);
        int   c0;
        int   key;
        exp_t e;
        key = i * 512 + int'(a);
        @(posedge clk);
        #1;
        c0 = cyc;
        rd[i] = r;
        wr[i] = w;
        addr_w[i] = a;
        din_w[i] = d;
        if (r) exp_dout[i] = model.exists(key) ? model[key] : 32'h0;
        if (w) model[key] = d;
        e.inst = i;
        e.dout = exp_dout[i];
        e.due  = c0 + 2 + ws(i);
        sb.push_back(e);
        $display("req inst%0d %s addr=%h data=%h hold=%0d due=%0d", i, r ? "read" : "write", a, d, hold, e.due);
        @(posedge clk);
        #1;
        if (scramble) begin
            addr_w[i] = a ^ 9'h001;
            din_w[i]  = ~d;
        end
        @(negedge clk);
        checks++;
        if (busy_w[i] !== 1'b1) begin
            errors++;
            $display("FAIL busy_on_accept inst%0d: got %b, expected 1", i, busy_w[i]);
        end
        for (int h = 1; h < hold; h++) @(posedge clk);
        #1;
        rd[i] = 1'b0;
        wr[i] = 1'b0;
        wait_drain(i);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks += 4;
            if (dout_w[i] !== 32'h0) begin errors++; $display("FAIL reset_data_out inst%0d: got %h, expected 0", i, dout_w[i]); end
            if (done_w[i] !== 1'b0)  begin errors++; $display("FAIL reset_done inst%0d: got %b, expected 0", i, done_w[i]); end
            if (busy_w[i] !== 1'b0)  begin errors++; $display("FAIL reset_busy inst%0d: got %b, expected 0", i, busy_w[i]); end
            if (err_w[i] !== 1'b0)   begin errors++; $display("FAIL reset_err inst%0d: got %b, expected 0", i, err_w[i]); end
        end
        @(posedge clk);
        #1;
        clr = 3'b000;
        for (int i = 0; i < 3; i++) exp_dout[i] = 32'h0;
        $display("reset released");
    endtask

    task automatic test_write_read;
        do_req(0, 1'b0, 1'b1, 9'h054, 32'h0000_0078, 1, 1'b0);
        do_req(0, 1'b1, 1'b0, 9'h054, 32'h0, 1, 1'b0);
        checks++;
        if (dout_w[0] !== 32'h0000_0078) begin
            errors++;
            $display("FAIL write_read_data: got %h, expected 00000078", dout_w[0]);
        end
    endtask

    task automatic test_held_read;
        do_req(1, 1'b0, 1'b1, 9'h020, 32'h0BAD_CAFE, 1, 1'b0);
        do_req(1, 1'b1, 1'b0, 9'h020, 32'h0, 2, 1'b0);
        do_req(1, 1'b1, 1'b0, 9'h020, 32'h0, 4, 1'b0);
    endtask

    task automatic test_conflict;
        do_req(0, 1'b0, 1'b1, 9'h100, 32'hA5A5_0001, 1, 1'b0);
        @(posedge clk);
        #1;
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        addr_w[0] = 9'h100;
        din_w[0] = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (err_w[0] !== 1'b1)  begin errors++; $display("FAIL conflict_err: got %b, expected 1", err_w[0]); end
        if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL conflict_busy: got %b, expected 0", busy_w[0]); end
        @(negedge clk);
        checks++;
        if (err_w[0] !== 1'b0) begin errors++; $display("FAIL conflict_err_pulse: got %b, expected 0", err_w[0]); end
        $display("conflict inst0 err pulse checked");
        @(posedge clk);
        #1;
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        do_req(0, 1'b1, 1'b0, 9'h100, 32'h0, 1, 1'b0);
    endtask

    task automatic test_clear_abort;
        do_req(2, 1'b0, 1'b1, 9'h010, 32'h1111_2222, 1, 1'b0);
        do_req(2, 1'b1, 1'b0, 9'h010, 32'h0, 1, 1'b0);
        @(posedge clk);
        #1;
        wr[2] = 1'b1;
        addr_w[2] = 9'h010;
        din_w[2] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        clr[2] = 1'b1;
        wr[2] = 1'b0;
        @(posedge clk);
        #1;
        clr[2] = 1'b0;
        exp_dout[2] = 32'h0;
        @(negedge clk);
        checks += 2;
        if (dout_w[2] !== 32'h0) begin errors++; $display("FAIL abort_data_out: got %h, expected 0", dout_w[2]); end
        if (busy_w[2] !== 1'b0)  begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy_w[2]); end
        $display("abort inst2 clear applied mid-wait");
        repeat (8) @(negedge clk);
        do_req(2, 1'b1, 1'b0, 9'h010, 32'h0, 1, 1'b0);
    endtask

    task automatic test_latched_operands;
        do_req(0, 1'b0, 1'b1, 9'h0AB, 32'h0000_0000, 1, 1'b0);
        do_req(0, 1'b0, 1'b1, 9'h0AA, 32'hCAFE_F00D, 2, 1'b1);
        do_req(0, 1'b1, 1'b0, 9'h0AA, 32'h0, 1, 1'b0);
        do_req(0, 1'b1, 1'b0, 9'h0AB, 32'h0, 1, 1'b0);
    endtask

    task automatic test_held_across_clear;
        @(posedge clk);
        #1;
        rd[1] = 1'b1;
        addr_w[1] = 9'h020;
        clr[1] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        clr[1] = 1'b0;
        exp_dout[1] = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (busy_w[1] !== 1'b0) begin
                errors++;
                $display("FAIL held_clear_busy cycle %0d: got %b, expected 0", k, busy_w[1]);
            end
        end
        $display("held read across clear: not accepted");
        @(posedge clk);
        #1;
        rd[1] = 1'b0;
        do_req(1, 1'b1, 1'b0, 9'h020, 32'h0, 1, 1'b0);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   c0;
        do_req(0, 1'b0, 1'b1, 9'h0C1, 32'h0000_0055, 1, 1'b0);
        @(posedge clk);
        #1;
        c0 = cyc;
        wr[0] = 1'b1;
        addr_w[0] = 9'h0C0;
        din_w[0] = 32'h0000_0077;
        model[0 * 512 + 'h0C0] = 32'h0000_0077;
        e.inst = 0;
        e.dout = exp_dout[0];
        e.due  = c0 + 3;
        sb.push_back(e);
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        @(posedge clk);
        #1;
        // Second rising request lands while the first is in flight and must be dropped.
        wr[0] = 1'b1;
        addr_w[0] = 9'h0C1;
        din_w[0] = 32'h0000_0099;
        $display("req inst0 write while busy addr=0c1 (expected dropped)");
        repeat (3) @(posedge clk);
        #1;
        wr[0] = 1'b0;
        wait_drain(0);
        do_req(0, 1'b1, 1'b0, 9'h0C1, 32'h0, 1, 1'b0);
        do_req(0, 1'b1, 1'b0, 9'h0C0, 32'h0, 1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            addr_w[i] = '0;
            din_w[i]  = '0;
            exp_dout[i] = '0;
        end
        test_reset();
        test_write_read();
        test_held_read();
        test_conflict();
        test_clear_abort();
        test_latched_operands();
        test_held_across_clear();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
